// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: fetch, write-back and execute signals around the decode-issue stage
interface decode_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_opcode;
    logic [6:0]      out_func7;
    logic [2:0]      out_func3;
    logic            out_alu_src;
    logic            out_mem_write;
    logic [2:0]      out_mem_load_type;
    logic [1:0]      out_mem_store_type;
    logic            out_wb_load;
    logic            out_wb_reg_file;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_rs1, out_rs2,
               out_opcode, out_func7, out_func3, out_alu_src, out_mem_write, out_mem_load_type,
               out_mem_store_type, out_wb_load, out_wb_reg_file, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_rs1, out_rs2,
               out_opcode, out_func7, out_func3, out_alu_src, out_mem_write, out_mem_load_type,
               out_mem_store_type, out_wb_load, out_wb_reg_file, out_illegal
    );
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32IM decode, register read with write-back bypass, ID/EX register with load-use stall
module decode_issue_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    decode_issue_stage_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      opcode;
        logic [6:0]      func7;
        logic [2:0]      func3;
        logic            alu_src;
        logic            mem_write;
        logic [2:0]      load_type;
        logic [1:0]      store_type;
        logic            wb_load;
        logic            wb_reg_file;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] rf_q [REG_COUNT];
    logic            valid_q;
    idex_t           id_q, id_d;
    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [AW-1:0]   rs1a, rs2a, wa, rda_q;
    logic [31:0]     imm32;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic            rs1_used, rs2_used, adv, hazard, accept;

    assign ins       = bus.in_instr;
    assign opc       = ins[6:0];
    assign rs1a      = ins[15 +: AW];
    assign rs2a      = ins[20 +: AW];
    assign wa        = bus.wb_addr[AW-1:0];
    assign rda_q     = id_q.rd[AW-1:0];
    assign is_lui    = opc == OP_LUI;
    assign is_auipc  = opc == OP_AUIPC;
    assign is_jal    = opc == OP_JAL;
    assign is_jalr   = opc == OP_JALR;
    assign is_branch = opc == OP_BRANCH;
    assign is_load   = opc == OP_LOAD;
    assign is_store  = opc == OP_STORE;
    assign is_opimm  = opc == OP_OPIMM;
    assign is_op     = opc == OP_OP;
    assign rs1_used  = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
    assign rs2_used  = is_branch | is_store | is_op;

    // A draining load whose rd feeds the presented instruction forces one bubble
    assign adv      = !valid_q | bus.out_ready;
    assign hazard   = valid_q & id_q.wb_load & (rda_q != '0) &
                      ((rs1_used & (rs1a == rda_q)) | (rs2_used & (rs2a == rda_q)));
    assign bus.in_ready = adv & !hazard & !bus.flush;
    assign accept   = bus.in_valid & bus.in_ready;

    // Immediate selection by instruction format, then widened to XLEN
    always_comb
        imm32 = is_store  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                is_branch ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                is_jal    ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                (is_lui | is_auipc) ? {ins[31:12], 12'h0} :
                {{20{ins[31]}}, ins[31:20]};

    // Next ID/EX contents: decoded controls plus operands with same-cycle write-back bypass
    always_comb begin
        id_d.pc          = bus.in_pc;
        id_d.op1         = (rs1a == '0) ? '0 :
                           (BYPASS_EN && bus.wb_en && wa == rs1a) ? bus.wb_data : rf_q[rs1a];
        id_d.op2         = (rs2a == '0) ? '0 :
                           (BYPASS_EN && bus.wb_en && wa == rs2a) ? bus.wb_data : rf_q[rs2a];
        id_d.imm         = XLEN'(signed'(imm32));
        id_d.rd          = ins[11:7];
        id_d.rs1         = ins[19:15];
        id_d.rs2         = ins[24:20];
        id_d.opcode      = opc;
        id_d.func7       = ins[31:25];
        id_d.func3       = ins[14:12];
        id_d.alu_src     = is_opimm | is_load | is_store | is_jalr | is_lui | is_auipc;
        id_d.mem_write   = is_store;
        id_d.load_type   = is_load ? ins[14:12] : 3'd0;
        id_d.store_type  = is_store ? ins[13:12] : 2'd0;
        id_d.wb_load     = is_load;
        id_d.wb_reg_file = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) &
                           (ins[11:7] != 5'd0);
        id_d.illegal     = !(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                             is_store | is_opimm | is_op);
    end

    // Register file write; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        else if (bus.wb_en && wa != '0)
            rf_q[wa] <= bus.wb_data;

    // ID/EX register: flush empties it, otherwise it advances when execute can take its contents
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
        end else if (bus.flush)
            valid_q <= 1'b0;
        else if (adv) begin
            valid_q <= accept;
            if (accept) id_q <= id_d;
        end

    assign bus.out_valid          = valid_q;
    assign bus.out_pc             = id_q.pc;
    assign bus.out_op1            = id_q.op1;
    assign bus.out_op2            = id_q.op2;
    assign bus.out_imm            = id_q.imm;
    assign bus.out_rd             = id_q.rd;
    assign bus.out_rs1            = id_q.rs1;
    assign bus.out_rs2            = id_q.rs2;
    assign bus.out_opcode         = id_q.opcode;
    assign bus.out_func7          = id_q.func7;
    assign bus.out_func3          = id_q.func3;
    assign bus.out_alu_src        = id_q.alu_src;
    assign bus.out_mem_write      = id_q.mem_write;
    assign bus.out_mem_load_type  = id_q.load_type;
    assign bus.out_mem_store_type = id_q.store_type;
    assign bus.out_wb_load        = id_q.wb_load;
    assign bus.out_wb_reg_file    = id_q.wb_reg_file;
    assign bus.out_illegal        = id_q.illegal;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: scoreboard bench for the decode-issue stage
module tb_decode_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_issue_stage_if #(.XLEN(32)) bus();
    decode_issue_stage #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        alu;
        logic        wbrf;
        logic        wbld;
        logic        mw;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic exp_t observed();
        return exp_t'{bus.out_pc, bus.out_op1, bus.out_op2, bus.out_imm, bus.out_rd,
                      bus.out_alu_src, bus.out_wb_reg_file, bus.out_wb_load, bus.out_mem_write,
                      bus.out_mem_load_type, bus.out_mem_store_type, bus.out_illegal};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_pc    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (observed() !== exp_t'(0)) $display("FAIL reset_fields: got %h want 0", observed());
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_decode_bypass();
        cyc();
        wb(1'b1, 5'd1, 32'h10);
        drive(1'b1, 32'hFFF08113, 32'h100);
        sb.push_back(exp_t'{32'h100, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bypass_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        cyc();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", bus.out_valid);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (observed() !== e) $display("FAIL decode_addi: got %h want %h", observed(), e);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [6];
        exp_t        ex  [6];
        ins[0] = 32'h0020A223; ex[0] = exp_t'{32'h200, 32'h10, 32'h22, 32'h4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0};
        ins[1] = 32'hFE208CE3; ex[1] = exp_t'{32'h204, 32'h10, 32'h22, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        ins[2] = 32'hFFDFF06F; ex[2] = exp_t'{32'h208, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        ins[3] = 32'h123453B7; ex[3] = exp_t'{32'h20C, 32'h0, 32'h0, 32'h1234_5000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        ins[4] = 32'h00000000; ex[4] = exp_t'{32'h210, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1};
        ins[5] = 32'h00500413; ex[5] = exp_t'{32'h214, 32'h0, 32'h0, 32'h5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
        wb(1'b1, 5'd2, 32'h22);
        cyc();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) wb(1'b1, 5'd0, 32'hDEAD);
            else wb(1'b0, 5'd0, 32'h0);
            drive(1'b1, ins[k], 32'h200 + 32'(4 * k));
            sb.push_back(ex[k]);
            #1;
            total_cnt++;
            if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, bus.in_ready);
            else pass_cnt++;
            cyc();
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k, bus.out_valid);
            else pass_cnt++;
            e = sb.pop_front();
            total_cnt++;
            if (observed() !== e) $display("FAIL b2b_decode[%0d]: got %h want %h", k, observed(), e);
            else pass_cnt++;
        end
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0000A183, 32'h300);
        sb.push_back(exp_t'{32'h300, 32'h10, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 2'd0, 1'b0});
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL lu_lw_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL lu_valid0: got %b want 1", bus.out_valid);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (observed() !== e) $display("FAIL lu_lw: got %h want %h", observed(), e);
        else pass_cnt++;
        drive(1'b1, 32'h00118233, 32'h304);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL lu_hazard: got %b want 0", bus.in_ready);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL lu_bubble: got %b want 0", bus.out_valid);
        else pass_cnt++;
        wb(1'b1, 5'd3, 32'h33);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL lu_add_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        sb.push_back(exp_t'{32'h304, 32'h33, 32'h10, 32'h1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        cyc();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL lu_valid2: got %b want 1", bus.out_valid);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (observed() !== e) $display("FAIL lu_add: got %h want %h", observed(), e);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'hFFF08113, 32'h400);
        sb.push_back(exp_t'{32'h400, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        cyc();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h123453B7, 32'h404);
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
            else pass_cnt++;
            total_cnt++;
            if (bus.out_valid !== 1'b1 || observed() !== e)
                $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, bus.out_valid, observed(), e);
            else pass_cnt++;
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        sb.push_back(exp_t'{32'h404, 32'h0, 32'h33, 32'h1234_5000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        e = sb.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || observed() !== e)
            $display("FAIL bp_release: got v=%b %h want v=1 %h", bus.out_valid, observed(), e);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hFFF08113, 32'h500);
        sb.push_back(exp_t'{32'h500, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        cyc();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 32'h123453B7, 32'h504);
        e = sb.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || observed() !== e)
            $display("FAIL flush_pre: got v=%b %h want v=1 %h", bus.out_valid, observed(), e);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        cyc();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_no_accept: got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wb(1'b1, 5'd5, 32'h55);
        drive(1'b1, 32'hFFF08113, 32'h600);
        sb.push_back(exp_t'{32'h600, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        cyc();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        e = sb.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || observed() !== e)
            $display("FAIL rm_pre: got v=%b %h want v=1 %h", bus.out_valid, observed(), e);
        else pass_cnt++;
        cyc();
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rm_async_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (observed() !== exp_t'(0)) $display("FAIL rm_async_fields: got %h want 0", observed());
        else pass_cnt++;
        sb.delete();
        cyc();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00028333, 32'h604);
        sb.push_back(exp_t'{32'h604, 32'h0, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0});
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL rm_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        e = sb.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || observed() !== e)
            $display("FAIL rm_x5_zero: got v=%b %h want v=1 %h", bus.out_valid, observed(), e);
        else pass_cnt++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_decode_bypass();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
